// File: rtl/controller_pkg.sv
// Shared state type and default timing for the controller scan scheduler.
package controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        PULSE_HI,
        PULSE_LO,
        DONE
    } state_t;

    localparam int unsigned DEF_LATCH_CYCLES = 600;
    localparam int unsigned DEF_PHASE_CYCLES = 300;
    localparam int unsigned DEF_FRAME_CYCLES = 833334;
    localparam int unsigned PULSE_PERIODS    = 7;
    localparam int unsigned BTN_BITS         = 8;

endpackage

// File: rtl/flex_counter.sv
// Up-counter 0..rollover_val that wraps to 0; synchronous clear has priority over counting.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            count_out <= (count_out == rollover_val) ? '0 : count_out + 1'b1;
        end
    end

endmodule

// File: rtl/flex_stp_sr.sv
// Serial-to-parallel shift register; resets to all ones (no buttons pressed).
module flex_stp_sr #(
    parameter int unsigned NUM_BITS  = 4,
    parameter bit          SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] parallel_out
);

    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            parallel_out <= '1;
        end else if (shift_enable) begin
            parallel_out <= SHIFT_MSB ? {parallel_out[NUM_BITS-2:0], serial_in}
                                      : {serial_in, parallel_out[NUM_BITS-1:1]};
        end
    end

endmodule

// File: rtl/controller_scan_scheduler.sv
// Periodic/on-demand scanner for two serial game controllers sharing latch and pulse lines.
module controller_scan_scheduler
    import controller_pkg::*;
#(
    parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES,
    parameter int unsigned PHASE_CYCLES = DEF_PHASE_CYCLES,
    parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                enable,
    input  logic                scan_req,
    input  logic                data_p0,
    input  logic                data_p1,
    output logic                latch,
    output logic                pulse,
    output logic [BTN_BITS-1:0] buttons_p0,
    output logic [BTN_BITS-1:0] buttons_p1,
    output logic                scan_done,
    output logic                changed,
    output logic                busy
);

    localparam int unsigned PHASE_MAX = (LATCH_CYCLES > PHASE_CYCLES) ? LATCH_CYCLES : PHASE_CYCLES;
    localparam int unsigned PW = $clog2(PHASE_MAX + 1);
    localparam int unsigned FW = $clog2(FRAME_CYCLES + 1);
    localparam int unsigned NW = $clog2(PULSE_PERIODS + 1);

    localparam logic [PW-1:0] LATCH_LAST = PW'(LATCH_CYCLES - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
    localparam logic [NW-1:0] PULSE_LAST = NW'(PULSE_PERIODS - 1);

    state_t              state, next_state;
    logic                pending;
    logic [FW-1:0]       frame_count;
    logic [PW-1:0]       phase_count, phase_last;
    logic [NW-1:0]       pulse_count;
    logic                frame_tick, trigger, scanning, phase_done, lo_done, sample;
    logic [BTN_BITS-1:0] sr_p0, sr_p1, capture_p0, capture_p1;
    logic                unused_msb;

    assign frame_tick = (frame_count == FRAME_LAST);
    assign trigger    = enable & (frame_tick | scan_req);
    assign scanning   = (state == LATCH) || (state == PULSE_HI) || (state == PULSE_LO);
    assign phase_last = (state == LATCH) ? LATCH_LAST : PHASE_LAST;
    assign phase_done = scanning && (phase_count == phase_last);
    assign lo_done    = (state == PULSE_LO) && phase_done;
    assign sample     = phase_done && ((state == LATCH) || (state == PULSE_LO));

    // Buttons load the post-shift value so the eighth sample lands on the DONE edge itself.
    assign capture_p0 = {sr_p0[BTN_BITS-2:0], data_p0};
    assign capture_p1 = {sr_p1[BTN_BITS-2:0], data_p1};
    assign unused_msb = sr_p0[BTN_BITS-1] ^ sr_p1[BTN_BITS-1];

    flex_counter #(.NUM_CNT_BITS(FW)) u_frame_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (1'b0),
        .count_enable (1'b1),
        .rollover_val (FRAME_LAST),
        .count_out    (frame_count)
    );

    flex_counter #(.NUM_CNT_BITS(PW)) u_phase_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (!scanning),
        .count_enable (scanning),
        .rollover_val (phase_last),
        .count_out    (phase_count)
    );

    flex_counter #(.NUM_CNT_BITS(NW)) u_pulse_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (state == IDLE),
        .count_enable (lo_done),
        .rollover_val (PULSE_LAST),
        .count_out    (pulse_count)
    );

    flex_stp_sr #(.NUM_BITS(BTN_BITS), .SHIFT_MSB(1'b1)) u_sr_p0 (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (sample),
        .serial_in    (data_p0),
        .parallel_out (sr_p0)
    );

    flex_stp_sr #(.NUM_BITS(BTN_BITS), .SHIFT_MSB(1'b1)) u_sr_p1 (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (sample),
        .serial_in    (data_p1),
        .parallel_out (sr_p1)
    );

    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (trigger) next_state = LATCH;
            LATCH:    if (phase_done) next_state = PULSE_HI;
            PULSE_HI: if (phase_done) next_state = PULSE_LO;
            PULSE_LO: if (phase_done) next_state = (pulse_count == PULSE_LAST) ? DONE : PULSE_HI;
            DONE:     next_state = ((pending & enable) | trigger) ? LATCH : IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Line and status outputs are decoded from next_state and registered, so they never glitch.
    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            latch      <= 1'b0;
            pulse      <= 1'b0;
            busy       <= 1'b0;
            scan_done  <= 1'b0;
            changed    <= 1'b0;
            pending    <= 1'b0;
            buttons_p0 <= '1;
            buttons_p1 <= '1;
        end else begin
            latch     <= (next_state == LATCH);
            pulse     <= (next_state == PULSE_HI);
            busy      <= (next_state != IDLE);
            scan_done <= (next_state == DONE);
            changed   <= (next_state == DONE) &&
                         ((capture_p0 != buttons_p0) || (capture_p1 != buttons_p1));
            if (next_state == DONE) begin
                buttons_p0 <= capture_p0;
                buttons_p1 <= capture_p1;
            end
            if (!enable || (state == DONE)) begin
                pending <= 1'b0;
            end else if (scanning && trigger) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_controller_scan_scheduler.sv
// Directed bench for controller_scan_scheduler with a behavioural serial controller model.
module tb_controller_scan_scheduler;

    localparam int unsigned L = 4;
    localparam int unsigned P = 2;
    localparam int unsigned F = 100;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       enable = 1'b0;
    logic       scan_req = 1'b0;
    logic       data_p0, data_p1;
    logic       latch, pulse, scan_done, changed, busy;
    logic [7:0] buttons_p0, buttons_p1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int npulses = 0;
    int nlatch = 0;
    logic prev_pulse_obs = 1'b0;
    logic prev_latch_obs = 1'b0;
    logic activity = 1'b0;
    logic [7:0] prev_b0 = 8'hFF;
    logic [7:0] prev_b1 = 8'hFF;

    // Controller model: parallel load while latch high, advance one bit on each pulse fall.
    logic [7:0] pat0 = 8'hFF;
    logic [7:0] pat1 = 8'hFF;
    logic [7:0] sreg0 = 8'hFF;
    logic [7:0] sreg1 = 8'hFF;
    logic       model_prev_pulse = 1'b0;

    assign data_p0 = sreg0[7];
    assign data_p1 = sreg1[7];

    always @(negedge clk) begin
        if (latch) begin
            sreg0 <= pat0;
            sreg1 <= pat1;
        end else if (model_prev_pulse && !pulse) begin
            sreg0 <= {sreg0[6:0], 1'b1};
            sreg1 <= {sreg1[6:0], 1'b1};
        end
        model_prev_pulse <= pulse;
    end

    controller_scan_scheduler #(
        .LATCH_CYCLES (L),
        .PHASE_CYCLES (P),
        .FRAME_CYCLES (F)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .enable     (enable),
        .scan_req   (scan_req),
        .data_p0    (data_p0),
        .data_p1    (data_p1),
        .latch      (latch),
        .pulse      (pulse),
        .buttons_p0 (buttons_p0),
        .buttons_p1 (buttons_p1),
        .scan_done  (scan_done),
        .changed    (changed),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge and run per-cycle invariants.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (n_rst) begin
            chk("latch_pulse_excl", 32'(latch & pulse), 32'd0);
            chk("btn_only_in_done",
                32'(((buttons_p0 != prev_b0) || (buttons_p1 != prev_b1)) && !scan_done), 32'd0);
        end
        if (pulse && !prev_pulse_obs) npulses++;
        if (latch && !prev_latch_obs) nlatch++;
        prev_pulse_obs = pulse;
        prev_latch_obs = latch;
        prev_b0 = buttons_p0;
        prev_b1 = buttons_p1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_latch", 32'(latch), 32'd0);
        chk("rst_pulse", 32'(pulse), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(scan_done), 32'd0);
        chk("rst_changed", 32'(changed), 32'd0);
        chk("rst_b0", 32'(buttons_p0), 32'hFF);
        chk("rst_b1", 32'(buttons_p1), 32'hFF);
        n_rst = 1'b1;
        cyc = 0;
        enable = 1'b1;
        pat0 = 8'h7E;
        pat1 = 8'hFF;

        // First software scan: trigger at 10, done at 43
        wait_cyc(10);
        chk("a_idle_latch", 32'(latch), 32'd0);
        chk("a_idle_busy", 32'(busy), 32'd0);
        scan_req = 1'b1;
        npulses = 0;
        tick();
        scan_req = 1'b0;
        chk("a_latch11", 32'(latch), 32'd1);
        chk("a_busy11", 32'(busy), 32'd1);
        wait_cyc(14);
        chk("a_latch14", 32'(latch), 32'd1);
        tick();
        chk("a_latch15", 32'(latch), 32'd0);
        chk("a_pulse15", 32'(pulse), 32'd1);
        tick();
        chk("a_pulse16", 32'(pulse), 32'd1);
        tick();
        chk("a_pulse17", 32'(pulse), 32'd0);
        wait_cyc(42);
        chk("a_done42", 32'(scan_done), 32'd0);
        chk("a_b0_42", 32'(buttons_p0), 32'hFF);
        tick();
        chk("a_done43", 32'(scan_done), 32'd1);
        chk("a_b0_43", 32'(buttons_p0), 32'h7E);
        chk("a_b1_43", 32'(buttons_p1), 32'hFF);
        chk("a_changed43", 32'(changed), 32'd1);
        chk("a_npulses", 32'(npulses), 32'd7);
        tick();
        chk("a_done44", 32'(scan_done), 32'd0);
        chk("a_changed44", 32'(changed), 32'd0);
        chk("a_busy44", 32'(busy), 32'd0);
        chk("a_b0_44", 32'(buttons_p0), 32'h7E);

        // Repeat scan at 70; requests at 75/80 and frame tick at 99 coalesce into one follow-up
        wait_cyc(70);
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        wait_cyc(75);
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        wait_cyc(80);
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        wait_cyc(90);
        pat1 = 8'h5A;
        wait_cyc(102);
        chk("b_done102", 32'(scan_done), 32'd0);
        nlatch = 0;
        tick();
        chk("b_done103", 32'(scan_done), 32'd1);
        chk("b_changed103", 32'(changed), 32'd0);
        chk("b_b0_103", 32'(buttons_p0), 32'h7E);
        chk("b_b1_103", 32'(buttons_p1), 32'hFF);
        tick();
        chk("b_latch104", 32'(latch), 32'd1);
        chk("b_done104", 32'(scan_done), 32'd0);
        wait_cyc(135);
        chk("b_done135", 32'(scan_done), 32'd0);
        tick();
        chk("b_done136", 32'(scan_done), 32'd1);
        chk("b_b1_136", 32'(buttons_p1), 32'h5A);
        chk("b_changed136", 32'(changed), 32'd1);
        tick();
        chk("b_busy137", 32'(busy), 32'd0);
        chk("b_latch137", 32'(latch), 32'd0);
        wait_cyc(180);
        chk("b_one_followup", 32'(nlatch), 32'd1);
        chk("b_busy180", 32'(busy), 32'd0);

        // Disabled for 300 cycles: frame ticks and a request are ignored
        wait_cyc(185);
        enable = 1'b0;
        activity = 1'b0;
        for (int i = 0; i < 300; i++) begin
            scan_req = (cyc == 249);
            tick();
            if (busy || latch || pulse) activity = 1'b1;
        end
        scan_req = 1'b0;
        chk("c_no_activity", 32'(activity), 32'd0);
        enable = 1'b1;
        wait_cyc(499);
        chk("c_latch499", 32'(latch), 32'd0);
        chk("c_busy499", 32'(busy), 32'd0);
        tick();
        chk("c_latch500", 32'(latch), 32'd1);
        wait_cyc(532);
        chk("c_done532", 32'(scan_done), 32'd1);
        chk("c_b0_532", 32'(buttons_p0), 32'h7E);
        chk("c_b1_532", 32'(buttons_p1), 32'h5A);
        chk("c_changed532", 32'(changed), 32'd0);

        // Reset during the 4th pulse-high phase
        wait_cyc(540);
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        wait_cyc(557);
        chk("d_pulse557", 32'(pulse), 32'd1);
        n_rst = 1'b0;
        #1;
        chk("d_rst_latch", 32'(latch), 32'd0);
        chk("d_rst_pulse", 32'(pulse), 32'd0);
        chk("d_rst_b0", 32'(buttons_p0), 32'hFF);
        chk("d_rst_b1", 32'(buttons_p1), 32'hFF);
        chk("d_rst_busy", 32'(busy), 32'd0);
        chk("d_rst_done", 32'(scan_done), 32'd0);
        prev_b0 = 8'hFF;
        prev_b1 = 8'hFF;
        tick();
        tick();
        n_rst = 1'b1;
        cyc = 0;
        wait_cyc(5);
        chk("d_no_resume_busy", 32'(busy), 32'd0);
        chk("d_no_resume_latch", 32'(latch), 32'd0);
        scan_req = 1'b1;
        npulses = 0;
        tick();
        scan_req = 1'b0;
        chk("d_latch6", 32'(latch), 32'd1);
        wait_cyc(37);
        chk("d_done37", 32'(scan_done), 32'd0);
        tick();
        chk("d_done38", 32'(scan_done), 32'd1);
        chk("d_b0_38", 32'(buttons_p0), 32'h7E);
        chk("d_b1_38", 32'(buttons_p1), 32'h5A);
        chk("d_changed38", 32'(changed), 32'd1);
        chk("d_npulses", 32'(npulses), 32'd7);
        tick();
        chk("d_busy39", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
